mc_price_engine: RTL and testbench
==================================

MC_PRICE_ENGINE -- requirements
Module: mc_price_engine

Interface
REQ-001 The block SHALL have parameter SAMPLE_W, default 11, meaning the signed normal-sample width.
REQ-002 The block SHALL have parameter VAL_W, default 16, meaning the unsigned price/strike/coefficient width.
REQ-003 The block SHALL have parameter LOG_PATHS, default 10, meaning the path count is 2^LOG_PATHS per run.
REQ-004 The block SHALL have parameter FRAC, default 8, meaning the fixed-point fraction bits of sigmaSqrtT and of the intermediate term d.
REQ-005 Ports SHALL be as follows; one clock; reset is asynchronous and active-low.
- clk  in  1  clock; all state on rising edge.
- nreset  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a run; ignored while busy.
- mode_put  in  1  0=call, 1=put; sampled at accepted start.
- KerT  in  VAL_W  discounted strike; sampled at accepted start.
- Se05sigmaT  in  VAL_W  drift-adjusted spot; sampled at accepted start.
- sigmaSqrtT  in  VAL_W  volatility term, unsigned, FRAC fraction bits; sampled at accepted start.
- z_valid  in  1  normal sample valid.
- z  in  SAMPLE_W  signed normal sample.
- z_ready  out  1  sample accepted when z_valid && z_ready.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse when price is updated.
- price  out  VAL_W  averaged payoff of the last completed run.
- clamped  out  1  sticky per run: at least one S_T was saturated.

Function
REQ-006 The FSM SHALL have states IDLE, RUN, DRAIN, DONE.
REQ-007 In IDLE, start SHALL latch mode_put/KerT/Se05sigmaT/sigmaSqrtT, clear the accumulator, path counter and clamped, and move to RUN next cycle.
REQ-008 z_ready SHALL be 1 only in RUN; each handshake increments the path counter.
REQ-009 When the 2^LOG_PATHS-th sample is accepted, the FSM SHALL go to DRAIN; z_ready SHALL be 0 in that same next cycle.
REQ-010 Stage 1, registered: d = (sigmaSqrtT * z) >>> FRAC, signed, arithmetic (floor) shift.
REQ-011 Stage 2, registered: S_T = Se05sigmaT + ((Se05sigmaT * d) >>> FRAC), computed without truncation, then saturated to [0, 2^VAL_W-1]; clamped SHALL be set on saturation.
REQ-012 Payoff SHALL be max(S_T-KerT,0) for call and max(KerT-S_T,0) for put, added to an unsigned VAL_W+LOG_PATHS-bit accumulator; overflow is impossible by width.
REQ-013 Sample-to-accumulator latency SHALL be 3 cycles; DRAIN SHALL last until the pipeline is empty (3 cycles), then go to DONE.
REQ-014 DONE SHALL last 1 cycle: price = accumulator >> LOG_PATHS (floor), done=1, then IDLE.
REQ-015 busy SHALL be 1 in RUN, DRAIN and DONE, and 0 in IDLE.
REQ-016 price and clamped SHALL hold between runs; price changes only in DONE.
REQ-017 z_valid gaps SHALL stall counting without affecting the result; z_valid outside RUN SHALL be ignored.
REQ-018 start during busy SHALL be ignored; start in the DONE cycle SHALL be ignored.

Reset
REQ-019 nreset low SHALL force IDLE immediately, clear pipeline valids, the accumulator and the counter, and set busy=0, done=0, z_ready=0, price=0, clamped=0, including mid-run; no done SHALL follow.

Structure
REQ-020 The FSM state encoding and default parameter constants SHALL be in shared package mc_price_pkg.
REQ-021 The two-stage payoff datapath SHALL be sub-module mc_payoff_pipe; the FSM, counter and accumulator stay in the top level.

Verification (KerT=11017, Se05sigmaT=12820, sigmaSqrtT=110, LOG_PATHS=10 unless stated)
REQ-022 Call, z=0 for all 1024 paths -> price=1803, clamped=0, a single done pulse.
REQ-023 Put, z=0 -> price=0; call, z=+256 -> S_T=18328, price=7311.
REQ-024 Put, z=-1024 -> S_T saturates to 0, price=11017, clamped=1.
REQ-025 Random z_valid gaps, call, z=0 -> price=1803; z_ready low outside RUN; start pulses while busy are ignored.
REQ-026 nreset asserted after 500 samples -> all outputs 0 and no done; a new start then gives a correct full run.

Source files
------------

// File: rtl/mc_price_pkg.sv
// -----------------------------------------------------------------------------
// mc_price_pkg
// Shared definitions for the Monte-Carlo option price engine:
//   - state_t     : run-control FSM encoding (IDLE, RUN, DRAIN, DONE)
//   - DEF_*       : default parameter values for the engine
//   - PIPE_LAT    : sample-to-accumulator latency in cycles
// -----------------------------------------------------------------------------
package mc_price_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_SAMPLE_W  = 11;
    localparam int DEF_VAL_W     = 16;
    localparam int DEF_LOG_PATHS = 10;
    localparam int DEF_FRAC      = 8;

    // Accepted sample -> stage 1 -> stage 2 -> accumulator.
    localparam int PIPE_LAT = 3;

endpackage

// File: rtl/mc_payoff_pipe.sv
// -----------------------------------------------------------------------------
// mc_payoff_pipe
// Two registered stages turning one normal sample into one path payoff.
//   stage 1 : d   = (sigma * z) >>> FRAC                 (signed, floor)
//   stage 2 : S_T = se + ((se * d) >>> FRAC), saturated to [0, 2^VAL_W-1]
//   output  : payoff = max(S_T-K,0) (call) or max(K-S_T,0) (put), combinational
//             from the stage-2 register.
// Ports:
//   clk, nreset      clock, async active-low reset (clears stage valids)
//   i_valid, i_z     sample strobe and signed sample
//   i_sigma, i_se,   run constants (held stable by the caller during a run)
//   i_kert, i_put
//   o_valid          payoff valid (one cycle per accepted sample, 2 cycles later)
//   o_payoff         path payoff
//   o_sat            S_T of this path was saturated
// -----------------------------------------------------------------------------
module mc_payoff_pipe #(
    parameter int SAMPLE_W = 11,
    parameter int VAL_W    = 16,
    parameter int FRAC     = 8
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic                i_valid,
    input  logic [SAMPLE_W-1:0] i_z,
    input  logic [VAL_W-1:0]    i_sigma,
    input  logic [VAL_W-1:0]    i_se,
    input  logic [VAL_W-1:0]    i_kert,
    input  logic                i_put,
    output logic                o_valid,
    output logic [VAL_W-1:0]    o_payoff,
    output logic                o_sat
);

    // Widths large enough that no product or sum is ever truncated.
    localparam int D_W = VAL_W + SAMPLE_W + 1;
    localparam int P_W = VAL_W + 1 + D_W;
    localparam int S_W = P_W + 1;

    logic signed [D_W-1:0] w_sig_s, w_z_s, w_prod1, w_d;
    logic signed [P_W-1:0] w_se_p, w_d_p, w_prod2, w_term;
    logic signed [S_W-1:0] w_st;
    logic [VAL_W-1:0]      w_st_sat;
    logic                  w_sat;

    logic                  r_v1, r_v2;
    logic signed [D_W-1:0] r_d;
    logic [VAL_W-1:0]      r_st;
    logic                  r_sat;

    assign w_sig_s = $signed({{(D_W-VAL_W){1'b0}}, i_sigma});
    assign w_z_s   = $signed({{(D_W-SAMPLE_W){i_z[SAMPLE_W-1]}}, i_z});
    assign w_prod1 = w_sig_s * w_z_s;
    assign w_d     = w_prod1 >>> FRAC;

    assign w_se_p  = $signed({{(P_W-VAL_W){1'b0}}, i_se});
    assign w_d_p   = $signed({{(P_W-D_W){r_d[D_W-1]}}, r_d});
    assign w_prod2 = w_se_p * w_d_p;
    assign w_term  = w_prod2 >>> FRAC;
    assign w_st    = $signed({w_term[P_W-1], w_term}) +
                     $signed({{(S_W-VAL_W){1'b0}}, i_se});

    // Negative -> 0, anything above the VAL_W range -> all ones.
    always_comb begin
        w_st_sat = w_st[VAL_W-1:0];
        w_sat    = 1'b0;
        if (w_st[S_W-1]) begin
            w_st_sat = '0;
            w_sat    = 1'b1;
        end else if (|w_st[S_W-2:VAL_W]) begin
            w_st_sat = '1;
            w_sat    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
            r_d   <= '0;
            r_st  <= '0;
            r_sat <= 1'b0;
        end else begin
            r_v1 <= i_valid;
            r_v2 <= r_v1;
            if (i_valid) r_d <= w_d;
            if (r_v1) begin
                r_st  <= w_st_sat;
                r_sat <= w_sat;
            end
        end
    end

    always_comb begin
        o_payoff = '0;
        if (i_put) begin
            if (i_kert > r_st) o_payoff = i_kert - r_st;
        end else begin
            if (r_st > i_kert) o_payoff = r_st - i_kert;
        end
    end

    assign o_valid = r_v2;
    assign o_sat   = r_sat;

endmodule

// File: rtl/mc_price_engine.sv
// -----------------------------------------------------------------------------
// mc_price_engine
// Monte-Carlo European option pricer. A start in IDLE latches the run
// constants, then 2^LOG_PATHS normal samples are accepted over a valid/ready
// handshake, each mapped to a payoff and summed; the average is published.
// Handshake: a sample transfers on a rising edge where z_valid && z_ready;
// z_ready depends only on state, never on z_valid.
// Ports:
//   clk, nreset                 clock, async active-low reset
//   start, mode_put             run request (IDLE only), 0=call / 1=put
//   KerT, Se05sigmaT, sigmaSqrtT run constants, latched on accepted start
//   z_valid, z, z_ready         sample stream
//   busy                        RUN, DRAIN or DONE
//   done                        one-cycle pulse when price is updated
//   price                       averaged payoff of last completed run
//   clamped                     some S_T of the run was saturated
// -----------------------------------------------------------------------------
module mc_price_engine
    import mc_price_pkg::*;
#(
    parameter int SAMPLE_W  = DEF_SAMPLE_W,
    parameter int VAL_W     = DEF_VAL_W,
    parameter int LOG_PATHS = DEF_LOG_PATHS,
    parameter int FRAC      = DEF_FRAC
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic                start,
    input  logic                mode_put,
    input  logic [VAL_W-1:0]    KerT,
    input  logic [VAL_W-1:0]    Se05sigmaT,
    input  logic [VAL_W-1:0]    sigmaSqrtT,
    input  logic                z_valid,
    input  logic [SAMPLE_W-1:0] z,
    output logic                z_ready,
    output logic                busy,
    output logic                done,
    output logic [VAL_W-1:0]    price,
    output logic                clamped
);

    localparam int ACC_W = VAL_W + LOG_PATHS;

    state_t               r_state;
    logic [LOG_PATHS-1:0] r_cnt;
    logic [1:0]           r_drain;
    logic                 r_put;
    logic [VAL_W-1:0]     r_kert, r_se, r_sigma;
    logic [ACC_W-1:0]     r_acc;
    logic                 r_busy, r_z_ready, r_done, r_clamped;
    logic [VAL_W-1:0]     r_price;

    logic                 w_hs, w_pay_valid, w_sat;
    logic [VAL_W-1:0]     w_payoff;

    assign w_hs = z_valid && r_z_ready;

    mc_payoff_pipe #(
        .SAMPLE_W (SAMPLE_W),
        .VAL_W    (VAL_W),
        .FRAC     (FRAC)
    ) u_pipe (
        .clk      (clk),
        .nreset   (nreset),
        .i_valid  (w_hs),
        .i_z      (z),
        .i_sigma  (r_sigma),
        .i_se     (r_se),
        .i_kert   (r_kert),
        .i_put    (r_put),
        .o_valid  (w_pay_valid),
        .o_payoff (w_payoff),
        .o_sat    (w_sat)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_drain   <= '0;
            r_put     <= 1'b0;
            r_kert    <= '0;
            r_se      <= '0;
            r_sigma   <= '0;
            r_acc     <= '0;
            r_busy    <= 1'b0;
            r_z_ready <= 1'b0;
            r_done    <= 1'b0;
            r_price   <= '0;
            r_clamped <= 1'b0;
        end else begin
            // Payoffs arrive during RUN and DRAIN; the pipe is empty otherwise.
            if (w_pay_valid) begin
                r_acc <= r_acc + {{LOG_PATHS{1'b0}}, w_payoff};
                if (w_sat) r_clamped <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_put     <= mode_put;
                        r_kert    <= KerT;
                        r_se      <= Se05sigmaT;
                        r_sigma   <= sigmaSqrtT;
                        r_acc     <= '0;
                        r_cnt     <= '0;
                        r_clamped <= 1'b0;
                        r_busy    <= 1'b1;
                        r_z_ready <= 1'b1;
                        r_state   <= RUN;
                    end
                end
                RUN: begin
                    if (w_hs) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == '1) begin
                            r_z_ready <= 1'b0;
                            r_drain   <= '0;
                            r_state   <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Last payoff lands in the accumulator at the end of the
                    // second DRAIN cycle, so the third can publish it.
                    if (r_drain == 2'(PIPE_LAT - 1)) begin
                        r_price <= r_acc[ACC_W-1:LOG_PATHS];
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign z_ready = r_z_ready;
    assign busy    = r_busy;
    assign done    = r_done;
    assign price   = r_price;
    assign clamped = r_clamped;

endmodule

// File: tb/tb_mc_price_engine.sv
module tb_mc_price_engine;

    localparam int SW    = 11;
    localparam int VW    = 16;
    localparam int LP    = 10;
    localparam int FR    = 8;
    localparam int NPATH = 1 << LP;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          start = 1'b0;
    logic          mode_put = 1'b0;
    logic [VW-1:0] KerT = '0, Se05sigmaT = '0, sigmaSqrtT = '0;
    logic          z_valid = 1'b0;
    logic [SW-1:0] z = '0;
    logic          z_ready, busy, done, clamped;
    logic [VW-1:0] price;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    mc_price_engine #(.SAMPLE_W(SW), .VAL_W(VW), .LOG_PATHS(LP), .FRAC(FR)) dut (
        .clk(clk), .nreset(nreset), .start(start), .mode_put(mode_put),
        .KerT(KerT), .Se05sigmaT(Se05sigmaT), .sigmaSqrtT(sigmaSqrtT),
        .z_valid(z_valid), .z(z), .z_ready(z_ready), .busy(busy),
        .done(done), .price(price), .clamped(clamped)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;
    int zr_viol = 0;

    logic [VW-1:0] exp_q[$];
    logic          exp_c_q[$];
    int            zq[$];

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (z_ready && !busy) zr_viol++;
        if (done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                check("price", price, exp_q.pop_front());
                check("clamped", clamped, exp_c_q.pop_front());
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic longint fdiv(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    task automatic model(input bit put, input int k, input int se, input int sig,
                         output int p, output bit cl);
        longint sum, d, st, pay;
        sum = 0;
        cl  = 1'b0;
        foreach (zq[i]) begin
            d  = fdiv(longint'(sig) * zq[i], 1 << FR);
            st = se + fdiv(longint'(se) * d, 1 << FR);
            if (st < 0) begin st = 0; cl = 1'b1; end
            if (st > (1 << VW) - 1) begin st = (1 << VW) - 1; cl = 1'b1; end
            pay = put ? (k - st) : (st - k);
            if (pay < 0) pay = 0;
            sum += pay;
        end
        p = int'(sum / NPATH);
    endtask

    // ---------------- drivers ----------------
    task automatic start_run(input bit put, input int k, input int se, input int sig);
        @(negedge clk);
        start = 1'b1; mode_put = put;
        KerT = VW'(k); Se05sigmaT = VW'(se); sigmaSqrtT = VW'(sig);
        @(negedge clk);
        start = 1'b0;
        // Scramble the constants to show they were latched.
        KerT = VW'($urandom); Se05sigmaT = VW'($urandom); sigmaSqrtT = VW'($urandom);
        mode_put = ~put;
    endtask

    // zmode 0: constant zc, 1: random full-range samples.
    task automatic feed(input int n, input int zmode, input int zc, input int gap_pct,
                        input bit noise);
        int acc = 0;
        int cyc = 0;
        int zi;
        bit v;
        while (acc < n && cyc < 20000) begin
            v  = ($urandom_range(0, 99) >= gap_pct);
            zi = zmode ? (int'($urandom_range(0, 2047)) - 1024) : zc;
            z_valid = v;
            z = SW'(zi);
            if (noise) begin
                start = ($urandom_range(0, 3) == 0);
                mode_put = $urandom_range(0, 1) == 1;
                KerT = VW'($urandom); Se05sigmaT = VW'($urandom);
            end
            if (v && z_ready) begin
                acc++;
                zq.push_back(zi);
            end
            @(negedge clk);
            cyc++;
        end
        z_valid = 1'b0;
        start = 1'b0;
        if (acc < n) check("feed_timeout", acc, n);
        if (n == NPATH) begin
            check("zready_after_last", z_ready, 0);
            check("busy_in_drain", busy, 1);
        end
    endtask

    task automatic wait_done(input bit start_in_done, input bit junk_z);
        int  cyc = 0;
        bit  seen = 1'b0;
        while (!seen && cyc < 20) begin
            if (junk_z) begin z_valid = 1'b1; z = SW'(500); end
            if (done) begin
                seen = 1'b1;
                if (start_in_done) start = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        z_valid = 1'b0;
        if (!seen) check("done_timeout", 0, 1);
        if (start_in_done) check("start_in_done_ignored", busy, 0);
    endtask

    task automatic run_case(input string name, input bit put, input int k, input int se,
                            input int sig, input int zmode, input int zc, input int gap,
                            input bit noise, input bit sid, input bit use_model,
                            input int ep, input bit ec);
        int p, d0, zv0;
        bit c;
        zq.delete();
        d0 = n_done;
        zv0 = zr_viol;
        start_run(put, k, se, sig);
        feed(NPATH, zmode, zc, gap, noise);
        if (use_model) model(put, k, se, sig, p, c);
        else begin p = ep; c = ec; end
        exp_q.push_back(VW'(p));
        exp_c_q.push_back(c);
        wait_done(sid, noise);
        repeat (3) @(negedge clk);
        check({name, "_done_count"}, n_done - d0, 1);
        check({name, "_zready_idle"}, zr_viol - zv0, 0);
        check({name, "_price_hold"}, price, p);
        check({name, "_idle"}, busy, 0);
    endtask

    typedef struct {
        bit put; int kert; int se; int sig; int zc; int exp_price; bit exp_cl;
    } vec_t;
    vec_t tbl[4];

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        tbl[0] = '{0, 11017, 12820, 110,     0,  1803, 1'b0};
        tbl[1] = '{1, 11017, 12820, 110,     0,     0, 1'b0};
        tbl[2] = '{0, 11017, 12820, 110,   256,  7311, 1'b0};
        tbl[3] = '{1, 11017, 12820, 110, -1024, 11017, 1'b1};

        repeat (3) @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_zready", z_ready, 0);
        check("rst_price", price, 0);
        check("rst_clamped", clamped, 0);

        // z_valid in IDLE must be ignored
        z_valid = 1'b1; z = SW'(300);
        repeat (4) @(negedge clk);
        z_valid = 1'b0;

        foreach (tbl[i])
            run_case($sformatf("vec%0d", i), tbl[i].put, tbl[i].kert, tbl[i].se,
                     tbl[i].sig, 0, tbl[i].zc, 0, 1'b0, 1'b0, 1'b0,
                     tbl[i].exp_price, tbl[i].exp_cl);

        // gaps, start noise while busy, junk z after the run, start in DONE
        run_case("gaps", 0, 11017, 12820, 110, 0, 0, 40, 1'b1, 1'b1, 1'b0, 1803, 1'b0);

        // random runs against the model
        for (int r = 0; r < 3; r++)
            run_case($sformatf("rand%0d", r), $urandom_range(0, 1) == 1,
                     int'($urandom_range(8000, 20000)), int'($urandom_range(8000, 30000)),
                     int'($urandom_range(0, 400)), 1, 0, 20, 1'b0, 1'b0, 1'b1, 0, 1'b0);

        // reset mid-run
        d0 = n_done;
        zq.delete();
        start_run(0, 11017, 12820, 200);
        feed(500, 1, 0, 0, 1'b0);
        nreset = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_zready", z_ready, 0);
        check("midrst_price", price, 0);
        check("midrst_clamped", clamped, 0);
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        repeat (10) @(negedge clk);
        check("midrst_no_done", n_done - d0, 0);
        check("midrst_busy_after", busy, 0);

        run_case("after_rst", 0, 11017, 12820, 110, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1803, 1'b0);

        check("exp_q_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
